// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of a PWM input,
// with stuck-line detection when no rising edge arrives in time.
module pwm_capture #(
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W:0]   duty,
  output logic [CNT_W:0]   period,
  output logic             vld,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] TO  = W'(TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    STUCK
  } state_t;

  state_t         state, state_nxt;
  logic           s1, s2, s3;
  logic           lvl, rise, to_hit;
  logic [W-1:0]   per_cnt, per_nxt, per_inc;
  logic [W-1:0]   high_cnt, high_nxt;
  logic [W-1:0]   duty_nxt, period_nxt;
  logic           vld_nxt, stuck_nxt, stuck_lvl_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl     = s2;
  assign rise    = s2 & ~s3;
  assign to_hit  = (per_cnt == TO);
  assign per_inc = to_hit ? per_cnt : per_cnt + ONE;

  always_comb begin
    state_nxt     = state;
    per_nxt       = per_inc;
    high_nxt      = high_cnt;
    duty_nxt      = duty;
    period_nxt    = period;
    vld_nxt       = 1'b0;
    stuck_nxt     = stuck;
    stuck_lvl_nxt = stuck_lvl;
    unique case (state)
      IDLE: begin
        // lvl carries reset zeros until the synchronizer has filled
        if (to_hit) begin
          state_nxt     = STUCK;
          stuck_nxt     = 1'b1;
          stuck_lvl_nxt = lvl;
        end else if (!lvl && per_cnt >= TWO) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (rise) begin
          state_nxt = MEAS;
          per_nxt   = ONE;
          high_nxt  = ONE;
        end else if (to_hit) begin
          state_nxt     = STUCK;
          stuck_nxt     = 1'b1;
          stuck_lvl_nxt = lvl;
        end
      end
      MEAS: begin
        if (rise) begin
          duty_nxt   = high_cnt;
          period_nxt = per_cnt;
          vld_nxt    = 1'b1;
          per_nxt    = ONE;
          high_nxt   = ONE;
        end else if (to_hit) begin
          state_nxt     = STUCK;
          stuck_nxt     = 1'b1;
          stuck_lvl_nxt = lvl;
        end else begin
          high_nxt = high_cnt + W'(lvl);
        end
      end
      STUCK: begin
        stuck_lvl_nxt = lvl;
        if (rise) begin
          state_nxt = MEAS;
          stuck_nxt = 1'b0;
          per_nxt   = ONE;
          high_nxt  = ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      per_cnt   <= '0;
      high_cnt  <= '0;
      duty      <= '0;
      period    <= '0;
      vld       <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
    end else begin
      state     <= state_nxt;
      per_cnt   <= per_nxt;
      high_cnt  <= high_nxt;
      duty      <= duty_nxt;
      period    <= period_nxt;
      vld       <= vld_nxt;
      stuck     <= stuck_nxt;
      stuck_lvl <= stuck_lvl_nxt;
    end
  end

endmodule
